// File: rtl/cnn_operand_packer.sv
// Packs a serial activation stream into PMU-lane vectors, each lane paired with its kernel weight.
// Optional zero-pad flush of a partial vector is compiled in with `define PACKER_ZERO_PAD_EN.
module cnn_operand_packer #(
  parameter int DATA_WIDTH         = 8,
  parameter int PARALLEL_MAC_UNITS = 4,
  parameter int KERNEL_TAPS        = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             act_valid,
  output logic                                             act_ready,
  input  logic signed [DATA_WIDTH-1:0]                     act_data,
  input  logic                                             flush_in,
  input  logic                                             wt_we,
  input  logic [$clog2(KERNEL_TAPS)-1:0]                   wt_addr,
  input  logic signed [DATA_WIDTH-1:0]                     wt_data,
  output logic                                             valid_out,
  input  logic                                             ready_in,
  output logic signed [PARALLEL_MAC_UNITS*DATA_WIDTH-1:0]  data_out,
  output logic signed [PARALLEL_MAC_UNITS*DATA_WIDTH-1:0]  weights_out,
  output logic                                             last_out
);

  localparam int PMU    = PARALLEL_MAC_UNITS;
  localparam int GROUPS = KERNEL_TAPS / PMU;
  localparam int AW     = $clog2(KERNEL_TAPS);
  localparam int LW     = (PMU > 1) ? $clog2(PMU) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [LW-1:0] LANE_LAST  = LW'(PMU - 1);
  localparam logic [GW-1:0] GROUP_LAST = GW'(GROUPS - 1);

  typedef logic signed [DATA_WIDTH-1:0] elem_t;

  elem_t           wt_mem_q [KERNEL_TAPS];

  elem_t           fill_data_q [PMU];
  elem_t           fill_data_d [PMU];
  elem_t           fill_wt_q   [PMU];
  elem_t           fill_wt_d   [PMU];
  logic            fill_last_q,  fill_last_d;
  logic            fill_full_q,  fill_full_d;
  logic [LW-1:0]   lane_cnt_q,   lane_cnt_d;
  logic [GW-1:0]   group_cnt_q,  group_cnt_d;

  elem_t           out_data_q [PMU];
  elem_t           out_data_d [PMU];
  elem_t           out_wt_q   [PMU];
  elem_t           out_wt_d   [PMU];
  logic            out_valid_q,  out_valid_d;
  logic            out_last_q,   out_last_d;

  logic            accept;
  logic            out_free;
  logic            flush_now;
  logic            complete;
  logic [AW-1:0]   rd_addr;
  elem_t           rd_wt;

  // Weight store: no reset, contents survive rst. Reads are combinational so a
  // same-cycle write to the read address is only visible from the next edge.
  always_ff @(posedge clk) begin
    if (wt_we) wt_mem_q[wt_addr] <= wt_data;
  end

`ifdef PACKER_ZERO_PAD_EN
  always_comb flush_now = act_valid && act_ready && flush_in;
`else
  logic unused_flush;
  always_comb unused_flush = flush_in;
  always_comb flush_now = 1'b0;
`endif

  always_comb begin
    accept   = act_valid && !fill_full_q;
    out_free = !out_valid_q || ready_in;
    rd_addr  = AW'(int'(group_cnt_q) * PMU + int'(lane_cnt_q));
    rd_wt    = wt_mem_q[rd_addr];

    fill_data_d = fill_data_q;
    fill_wt_d   = fill_wt_q;
    fill_last_d = fill_last_q;
    fill_full_d = fill_full_q;
    lane_cnt_d  = lane_cnt_q;
    group_cnt_d = group_cnt_q;
    out_data_d  = out_data_q;
    out_wt_d    = out_wt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    complete    = 1'b0;

    if (accept) begin
      for (int unsigned i = 0; i < PMU; i++) begin
        if (LW'(i) == lane_cnt_q) begin
          fill_data_d[i] = act_data;
          fill_wt_d[i]   = rd_wt;
        end else if (flush_now && (LW'(i) > lane_cnt_q)) begin
          fill_data_d[i] = '0;
          fill_wt_d[i]   = '0;
        end
      end
      if ((lane_cnt_q == LANE_LAST) || flush_now) begin
        complete    = 1'b1;
        lane_cnt_d  = '0;
        fill_last_d = (group_cnt_q == GROUP_LAST) || flush_now;
        group_cnt_d = (flush_now || (group_cnt_q == GROUP_LAST)) ? '0 : group_cnt_q + 1'b1;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end

    if (out_valid_q && ready_in) out_valid_d = 1'b0;

    // A vector completing this cycle bypasses the hold slot straight into the
    // output register when it is free; that bypass is what removes the bubble.
    if (complete || fill_full_q) begin
      if (out_free) begin
        out_data_d  = fill_data_d;
        out_wt_d    = fill_wt_d;
        out_last_d  = fill_last_d;
        out_valid_d = 1'b1;
        fill_full_d = 1'b0;
      end else begin
        fill_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_data_q <= '{default: '0};
      fill_wt_q   <= '{default: '0};
      fill_last_q <= 1'b0;
      fill_full_q <= 1'b0;
      lane_cnt_q  <= '0;
      group_cnt_q <= '0;
      out_data_q  <= '{default: '0};
      out_wt_q    <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      fill_data_q <= fill_data_d;
      fill_wt_q   <= fill_wt_d;
      fill_last_q <= fill_last_d;
      fill_full_q <= fill_full_d;
      lane_cnt_q  <= lane_cnt_d;
      group_cnt_q <= group_cnt_d;
      out_data_q  <= out_data_d;
      out_wt_q    <= out_wt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    act_ready   = !fill_full_q;
    valid_out   = out_valid_q;
    last_out    = out_last_q;
    data_out    = '0;
    weights_out = '0;
    for (int unsigned i = 0; i < PMU; i++) begin
      data_out[i*DATA_WIDTH +: DATA_WIDTH]    = out_data_q[i];
      weights_out[i*DATA_WIDTH +: DATA_WIDTH] = out_wt_q[i];
    end
  end

endmodule

// File: tb/tb_cnn_operand_packer.sv
// Scoreboard bench for cnn_operand_packer at default parameters (8-bit, 4 lanes, 16 taps).
module tb_cnn_operand_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        act_valid;
  logic        act_ready;
  logic [7:0]  act_data;
  logic        flush_in;
  logic        wt_we;
  logic [3:0]  wt_addr;
  logic [7:0]  wt_data;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] data_out;
  logic [31:0] weights_out;
  logic        last_out;

  cnn_operand_packer #(
    .DATA_WIDTH(8),
    .PARALLEL_MAC_UNITS(4),
    .KERNEL_TAPS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .flush_in(flush_in),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .weights_out(weights_out), .last_out(last_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] w;
    logic        l;
  } vec_t;

  vec_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   stalls = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] w, input logic l);
    vec_t v;
    v.d = d; v.w = w; v.l = l;
    exp_q.push_back(v);
  endtask

  // Monitor: every output handshake pops and compares one expected vector.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid_out && ready_in) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_vector: got data 0x%0h, no vector expected", data_out);
        end else begin
          e = exp_q.pop_front();
          check("vec_data", data_out, e.d);
          check("vec_weights", weights_out, e.w);
          check("vec_last", {31'd0, last_out}, {31'd0, e.l});
        end
      end
    end
  end

  task automatic send(input int d, input logic f);
    int n;
    act_valid = 1'b1;
    act_data  = 8'(d);
    flush_in  = f;
    n = 0;
    while (!act_ready && n < 200) begin
      stalls++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL send_timeout: act_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    act_valid = 1'b0;
    flush_in  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid_out", {31'd0, valid_out}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; act_valid = 1'b0; act_data = '0; flush_in = 1'b0;
    wt_we = 1'b0; wt_addr = '0; wt_data = '0; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valid_out", {31'd0, valid_out}, 0);
    check("reset_last_out", {31'd0, last_out}, 0);
    check("reset_act_ready", {31'd0, act_ready}, 1);
    check("reset_data_out", data_out, 0);
    check("reset_weights_out", weights_out, 0);

    for (int a = 0; a < 16; a++) begin
      wt_we = 1'b1; wt_addr = 4'(a); wt_data = 8'(a + 1);
      @(posedge clk); #1;
    end
    wt_we = 1'b0;

    // Basic streaming: four vectors, last on the fourth, one every 4 cycles.
    pop_cyc.delete();
    stalls = 0;
    push(pack4(1, 2, 3, 4),     pack4(1, 2, 3, 4),     1'b0);
    push(pack4(5, 6, 7, 8),     pack4(5, 6, 7, 8),     1'b0);
    push(pack4(9, 10, 11, 12),  pack4(9, 10, 11, 12),  1'b0);
    push(pack4(13, 14, 15, 16), pack4(13, 14, 15, 16), 1'b1);
    for (int i = 1; i <= 16; i++) send(i, 1'b0);
    drain();
    check("stream_no_stall", stalls, 0);
    check("stream_vec_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("stream_spacing", pop_cyc[i] - pop_cyc[i-1], 4);

    // Backpressure: first vector held, second parked, input stalls.
    ready_in = 1'b0;
    push(pack4(21, 22, 23, 24), pack4(1, 2, 3, 4),    1'b0);
    push(pack4(25, 26, 27, 28), pack4(5, 6, 7, 8),    1'b0);
    push(pack4(29, 30, 31, 32), pack4(9, 10, 11, 12), 1'b0);
    for (int i = 21; i <= 28; i++) send(i, 1'b0);
    check("bp_act_ready_low", {31'd0, act_ready}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", {31'd0, valid_out}, 1);
    check("bp_hold_data", data_out, pack4(21, 22, 23, 24));
    check("bp_hold_weights", weights_out, pack4(1, 2, 3, 4));
    check("bp_hold_last", {31'd0, last_out}, 0);
    ready_in = 1'b1;
    for (int i = 29; i <= 32; i++) send(i, 1'b0);
    drain();

    // Reset mid-vector: partial lanes discarded, group restarts at 0.
    send(7, 1'b0);
    send(7, 1'b0);
    do_reset();
    check("rst_mid_data_out", data_out, 0);
    check("rst_mid_act_ready", {31'd0, act_ready}, 1);
    push(pack4(9, 9, 9, 9), pack4(1, 2, 3, 4), 1'b0);
    for (int i = 0; i < 4; i++) send(9, 1'b0);
    drain();

    // Same-cycle write to the address being read returns the old weight.
    push(pack4(50, 51, 52, 53), pack4(5, 6, 7, 8),     1'b0);
    push(pack4(60, 61, 62, 63), pack4(9, 10, 11, 12),  1'b0);
    push(pack4(64, 65, 66, 67), pack4(13, 14, 15, 16), 1'b1);
    push(pack4(70, 71, 72, 73), pack4(1, 2, 3, 4),     1'b0);
    push(pack4(74, 75, 76, 77), pack4(100, 6, 7, 8),   1'b0);
    wt_we = 1'b1; wt_addr = 4'd4; wt_data = 8'd100;
    send(50, 1'b0);
    wt_we = 1'b0;
    for (int i = 51; i <= 53; i++) send(i, 1'b0);
    for (int i = 60; i <= 67; i++) send(i, 1'b0);
    for (int i = 70; i <= 77; i++) send(i, 1'b0);
    drain();

    do_reset();
`ifdef PACKER_ZERO_PAD_EN
    push(pack4(5, 6, 0, 0), pack4(1, 2, 0, 0), 1'b1);
    push(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 1'b0);
    send(5, 1'b0);
    send(6, 1'b1);
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
`else
    push(pack4(5, 6, 7, 8), pack4(1, 2, 3, 4), 1'b0);
    send(5, 1'b0);
    send(6, 1'b1);
    send(7, 1'b0);
    send(8, 1'b0);
`endif
    drain();

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
